// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: FSM states, wrap limits, segment patterns.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } sw_state_e;

  localparam int unsigned MAX_MM_DEFAULT = 59;
  localparam int unsigned MAX_SS_DEFAULT = 59;

  // Active-low {g..a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  function automatic logic [3:0] bcd_digit(input logic [6:0] v, input logic tens);
    return tens ? 4'(v / 7'd10) : 4'(v % 7'd10);
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Pulse/control inputs and time/display outputs of the stopwatch core.
interface stopwatch_core_if;
  logic       one_hz;
  logic       two_hz;
  logic       blink;
  logic       fast;
  logic       pause_btn;
  logic       adj;
  logic       sel;
  logic [6:0] mm;
  logic [6:0] ss;
  logic [3:0] an;
  logic [6:0] seg;
  logic       running;

  modport master (
    output one_hz, two_hz, blink, fast, pause_btn, adj, sel,
    input  mm, ss, an, seg, running
  );

  modport slave (
    input  one_hz, two_hz, blink, fast, pause_btn, adj, sel,
    output mm, ss, an, seg, running
  );
endinterface

// File: rtl/stopwatch_core_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment {g..a}; non-decimal codes blank.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (digit_i)
      4'd0:    seg_o = SEG_ZERO;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with run/pause/adjust FSM, 1-cycle counter latency and a registered 4-digit scan.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MM = MAX_MM_DEFAULT,
  parameter int unsigned MAX_SS = MAX_SS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_core_if.slave  bus
);

  localparam logic [6:0] MM_LIM = 7'(MAX_MM);
  localparam logic [6:0] SS_LIM = 7'(MAX_SS);

  sw_state_e  state_q, state_d;
  logic       pause_q, arm_q, pause_rise;
  logic [6:0] mm_q, mm_d, ss_q, ss_d;
  logic [1:0] idx_q;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, seg_raw;
  logic       running_q;
  logic [3:0] digit;
  logic       blank;

  // arm_q masks the first sample after reset so a button held through release is not an edge
  assign pause_rise = arm_q & bus.pause_btn & ~pause_q;

  always_comb begin
    state_d = state_q;
    if (bus.adj) begin
      state_d = ST_ADJUST;
    end else if (state_q == ST_ADJUST) begin
      state_d = ST_PAUSED;
    end else if (pause_rise) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end
  end

  always_comb begin
    mm_d = mm_q;
    ss_d = ss_q;
    if (state_q == ST_RUN && bus.one_hz) begin
      if (ss_q == SS_LIM) begin
        ss_d = '0;
        mm_d = (mm_q == MM_LIM) ? '0 : mm_q + 7'd1;
      end else begin
        ss_d = ss_q + 7'd1;
      end
    end else if (state_q == ST_ADJUST && bus.two_hz) begin
      if (bus.sel) ss_d = (ss_q == SS_LIM) ? '0 : ss_q + 7'd1;
      else         mm_d = (mm_q == MM_LIM) ? '0 : mm_q + 7'd1;
    end
  end

  // idx 3/2 = minutes tens/units, 1/0 = seconds tens/units
  assign digit = bcd_digit(idx_q[1] ? mm_q : ss_q, idx_q[0]);
  assign blank = (state_q == ST_ADJUST) && !bus.blink && (idx_q[1] != bus.sel);

  seg7_decode u_seg7_decode (
    .digit_i (digit),
    .seg_o   (seg_raw)
  );

  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_BLANK : seg_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PAUSED;
      pause_q   <= 1'b0;
      arm_q     <= 1'b0;
      mm_q      <= '0;
      ss_q      <= '0;
      idx_q     <= 2'd3;
      an_q      <= 4'b0111;
      seg_q     <= SEG_ZERO;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pause_q   <= bus.pause_btn;
      arm_q     <= 1'b1;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      if (bus.fast) idx_q <= idx_q - 2'd1;
      an_q      <= an_d;
      seg_q     <= seg_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign bus.mm      = mm_q;
  assign bus.ss      = ss_q;
  assign bus.an      = an_q;
  assign bus.seg     = seg_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core.
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  stopwatch_core_if sw ();

  stopwatch_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_one();
    sw.one_hz = 1'b1; cyc(1); sw.one_hz = 1'b0; cyc(1);
  endtask

  task automatic pulse_two();
    sw.two_hz = 1'b1; cyc(1); sw.two_hz = 1'b0; cyc(1);
  endtask

  task automatic pulse_fast();
    sw.fast = 1'b1; cyc(1); sw.fast = 1'b0; cyc(1);
  endtask

  task automatic press();
    sw.pause_btn = 1'b1; cyc(1); sw.pause_btn = 1'b0; cyc(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(2);
  endtask

  task automatic adjust_to(input int m, input int s);
    sw.adj = 1'b1; sw.sel = 1'b0; cyc(1);
    repeat (m) pulse_two();
    sw.sel = 1'b1;
    repeat (s) pulse_two();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc(1);
    checks++; if (sw.mm !== 7'd0) begin fails++; $display("FAIL reset_mm: got %0d want 0", sw.mm); end
    checks++; if (sw.ss !== 7'd0) begin fails++; $display("FAIL reset_ss: got %0d want 0", sw.ss); end
    checks++; if (sw.an !== 4'b0111) begin fails++; $display("FAIL reset_an: got %b want 0111", sw.an); end
    checks++; if (sw.seg !== 7'b1000000) begin fails++; $display("FAIL reset_seg: got %b want 1000000", sw.seg); end
    checks++; if (sw.running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b want 0", sw.running); end
    rst_n = 1'b1; cyc(2);
  endtask

  task automatic test_count();
    do_reset();
    press();
    checks++; if (sw.running !== 1'b1) begin fails++; $display("FAIL count_start_running: got %b want 1", sw.running); end
    sw.one_hz = 1'b1; cyc(1); sw.one_hz = 1'b0;
    checks++; if (sw.ss !== 7'd1) begin fails++; $display("FAIL count_latency_ss: got %0d want 1", sw.ss); end
    cyc(1);
    repeat (60) pulse_one();
    checks++; if (sw.mm !== 7'd1) begin fails++; $display("FAIL count61_mm: got %0d want 1", sw.mm); end
    checks++; if (sw.ss !== 7'd1) begin fails++; $display("FAIL count61_ss: got %0d want 1", sw.ss); end
    checks++; if (sw.running !== 1'b1) begin fails++; $display("FAIL count61_running: got %b want 1", sw.running); end
  endtask

  task automatic test_pause_start_tick();
    do_reset();
    sw.pause_btn = 1'b1; sw.one_hz = 1'b1; cyc(1);
    sw.pause_btn = 1'b0; sw.one_hz = 1'b0; cyc(1);
    checks++; if (sw.running !== 1'b1) begin fails++; $display("FAIL start_tick_running: got %b want 1", sw.running); end
    checks++; if (sw.ss !== 7'd0) begin fails++; $display("FAIL start_tick_ss: got %0d want 0", sw.ss); end
  endtask

  task automatic test_pause_stop_tick();
    pulse_one(); pulse_one();
    sw.pause_btn = 1'b1; sw.one_hz = 1'b1; cyc(1);
    sw.pause_btn = 1'b0; sw.one_hz = 1'b0; cyc(1);
    checks++; if (sw.ss !== 7'd3) begin fails++; $display("FAIL stop_tick_ss: got %0d want 3", sw.ss); end
    checks++; if (sw.running !== 1'b0) begin fails++; $display("FAIL stop_tick_running: got %b want 0", sw.running); end
    pulse_one();
    checks++; if (sw.ss !== 7'd3) begin fails++; $display("FAIL paused_ss_hold: got %0d want 3", sw.ss); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    adjust_to(59, 59);
    checks++; if (sw.mm !== 7'd59) begin fails++; $display("FAIL preload_mm: got %0d want 59", sw.mm); end
    checks++; if (sw.ss !== 7'd59) begin fails++; $display("FAIL preload_ss: got %0d want 59", sw.ss); end
    sw.adj = 1'b0; cyc(1);
    press();
    checks++; if (sw.running !== 1'b1) begin fails++; $display("FAIL wrap_running: got %b want 1", sw.running); end
    sw.one_hz = 1'b1; cyc(1); sw.one_hz = 1'b0;
    checks++; if (sw.mm !== 7'd0) begin fails++; $display("FAIL wrap_mm: got %0d want 0", sw.mm); end
    checks++; if (sw.ss !== 7'd0) begin fails++; $display("FAIL wrap_ss: got %0d want 0", sw.ss); end
    cyc(1);
  endtask

  task automatic test_adjust_wrap();
    do_reset();
    adjust_to(3, 59);
    pulse_two();
    checks++; if (sw.ss !== 7'd0) begin fails++; $display("FAIL adj_ss_wrap: got %0d want 0", sw.ss); end
    checks++; if (sw.mm !== 7'd3) begin fails++; $display("FAIL adj_no_carry_mm: got %0d want 3", sw.mm); end
    pulse_one();
    checks++; if (sw.ss !== 7'd0) begin fails++; $display("FAIL adj_onehz_ignored: got %0d want 0", sw.ss); end
    sw.sel = 1'b0;
    repeat (57) pulse_two();
    checks++; if (sw.mm !== 7'd0) begin fails++; $display("FAIL adj_mm_wrap: got %0d want 0", sw.mm); end
    checks++; if (sw.ss !== 7'd0) begin fails++; $display("FAIL adj_mm_no_carry_ss: got %0d want 0", sw.ss); end
    sw.adj = 1'b0; cyc(1);
  endtask

  task automatic test_blank();
    do_reset();
    adjust_to(12, 34);
    sw.sel = 1'b0; sw.blink = 1'b0; cyc(2);
    checks++; if (sw.an !== 4'b0111 || sw.seg !== 7'b1111111) begin fails++; $display("FAIL blank_mt: an %b seg %b want 0111 1111111", sw.an, sw.seg); end
    pulse_fast();
    checks++; if (sw.an !== 4'b1011 || sw.seg !== 7'b1111111) begin fails++; $display("FAIL blank_mu: an %b seg %b want 1011 1111111", sw.an, sw.seg); end
    pulse_fast();
    checks++; if (sw.an !== 4'b1101 || sw.seg !== 7'b0110000) begin fails++; $display("FAIL show_st: an %b seg %b want 1101 0110000", sw.an, sw.seg); end
    pulse_fast();
    checks++; if (sw.an !== 4'b1110 || sw.seg !== 7'b0011001) begin fails++; $display("FAIL show_su: an %b seg %b want 1110 0011001", sw.an, sw.seg); end
    sw.blink = 1'b1;
    pulse_fast();
    checks++; if (sw.an !== 4'b0111 || sw.seg !== 7'b1111001) begin fails++; $display("FAIL blink_on_mt: an %b seg %b want 0111 1111001", sw.an, sw.seg); end
    sw.sel = 1'b1; sw.blink = 1'b0; cyc(2);
    checks++; if (sw.seg !== 7'b1111001) begin fails++; $display("FAIL sel_ss_mt_visible: got %b want 1111001", sw.seg); end
    pulse_fast(); pulse_fast(); pulse_fast();
    checks++; if (sw.an !== 4'b1110 || sw.seg !== 7'b1111111) begin fails++; $display("FAIL sel_ss_su_blank: an %b seg %b want 1110 1111111", sw.an, sw.seg); end
    sw.adj = 1'b0; sw.blink = 1'b1; cyc(1);
  endtask

  task automatic test_reset_midrun();
    do_reset();
    adjust_to(5, 6);
    sw.adj = 1'b0; cyc(1);
    press();
    pulse_one();
    checks++; if (sw.mm !== 7'd5 || sw.ss !== 7'd7) begin fails++; $display("FAIL midrun_time: got %0d:%0d want 5:7", sw.mm, sw.ss); end
    sw.pause_btn = 1'b1; rst_n = 1'b0; cyc(1);
    checks++; if (sw.mm !== 7'd0 || sw.ss !== 7'd0) begin fails++; $display("FAIL midrun_reset_time: got %0d:%0d want 0:0", sw.mm, sw.ss); end
    rst_n = 1'b1; cyc(3);
    pulse_one();
    checks++; if (sw.running !== 1'b0) begin fails++; $display("FAIL held_btn_no_start: got %b want 0", sw.running); end
    checks++; if (sw.ss !== 7'd0) begin fails++; $display("FAIL held_btn_ss: got %0d want 0", sw.ss); end
    sw.pause_btn = 1'b0; cyc(1);
    press();
    checks++; if (sw.running !== 1'b1) begin fails++; $display("FAIL post_reset_edge: got %b want 1", sw.running); end
  endtask

  initial begin
    sw.one_hz = 1'b0; sw.two_hz = 1'b0; sw.blink = 1'b1; sw.fast = 1'b0;
    sw.pause_btn = 1'b0; sw.adj = 1'b0; sw.sel = 1'b0;
    test_reset();
    test_count();
    test_pause_start_tick();
    test_pause_stop_tick();
    test_full_wrap();
    test_adjust_wrap();
    test_blank();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
